// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port initiator for a 16x4 RAM with a registered read port.
//
// Accepts one read or write request at a time on a valid/ready request port,
// drives the RAM strobes from registers, captures read data exactly one cycle
// after the read strobe, and presents it on a valid/ready response port.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_wr/req_addr/req_wdata request kind (1 = write), word address, write data
//   rsp_valid/rsp_ready       response handshake (read data only)
//   rsp_data                  read data, held stable while rsp_valid is high
//   ram_en/ram_wr             RAM enable / write select strobes
//   ram_addr/ram_wdata        RAM address / write data
//   ram_rdata                 RAM registered read output
//   init_done                 high once the controller will accept traffic
//
// Build option:
//   RAM_CTRL_CLEAR_EN  when defined, reset enters an INIT sweep that writes 0
//                      to all 16 words before init_done rises. When undefined,
//                      init_done is 1 from reset and RAM contents are unspecified.

module ram_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [3:0] req_addr,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       ram_en,
  output logic       ram_wr,
  output logic [3:0] ram_addr,
  output logic [3:0] ram_wdata,
  input  logic [3:0] ram_rdata,
  output logic       init_done
);

`ifdef RAM_CTRL_CLEAR_EN
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_RDCAP = 3'd4,
    S_RSP   = 3'd5
  } state_t;
  localparam state_t RST_STATE     = S_INIT;
  localparam logic   RST_INIT_DONE = 1'b0;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_RDCAP = 3'd4,
    S_RSP   = 3'd5
  } state_t;
  localparam state_t RST_STATE     = S_IDLE;
  localparam logic   RST_INIT_DONE = 1'b1;
`endif

  state_t     state_q, state_d;
  logic       ram_en_q, ram_en_d;
  logic       ram_wr_q, ram_wr_d;
  logic [3:0] ram_addr_q, ram_addr_d;
  logic [3:0] ram_wdata_q, ram_wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       init_done_q, init_done_d;
`ifdef RAM_CTRL_CLEAR_EN
  // Counts 0..16: values 0..15 issue the clearing strobe, 16 ends the sweep.
  logic [4:0] init_cnt_q, init_cnt_d;
`endif

  assign req_ready = (state_q == S_IDLE) & init_done_q;
  assign ram_en    = ram_en_q;
  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_q;

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    ram_en_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    init_done_d = init_done_q;
`ifdef RAM_CTRL_CLEAR_EN
    init_cnt_d  = init_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // The request is latched straight into the strobe registers so the
        // RAM sees it in the cycle following acceptance.
        if (req_valid && req_ready) begin
          ram_en_d    = 1'b1;
          ram_wr_d    = req_wr;
          ram_addr_d  = req_addr;
          ram_wdata_d = req_wdata;
          state_d     = req_wr ? S_WRITE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_READ: begin
        state_d = S_RDCAP;
      end
      S_RDCAP: begin
        // The only cycle in which the RAM output is meaningful.
        rsp_data_d  = ram_rdata;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RSP;
        end
      end
`ifdef RAM_CTRL_CLEAR_EN
      S_INIT: begin
        if (init_cnt_q == 5'd16) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          ram_en_d    = 1'b1;
          ram_wr_d    = 1'b1;
          ram_addr_d  = init_cnt_q[3:0];
          ram_wdata_d = 4'h0;
          init_cnt_d  = init_cnt_q + 5'd1;
          state_d     = S_INIT;
        end
      end
`endif
      default: begin
        state_d     = RST_STATE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      ram_en_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= 4'h0;
      ram_wdata_q <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'h0;
      init_done_q <= RST_INIT_DONE;
`ifdef RAM_CTRL_CLEAR_EN
      init_cnt_q  <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      ram_en_q    <= ram_en_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
`ifdef RAM_CTRL_CLEAR_EN
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed, table-driven bench for ram_ctrl with a behavioural
// 16x4 RAM whose output is garbage whenever the previous cycle had no read.

module tb_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [3:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       ram_en;
  logic       ram_wr;
  logic [3:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;
  logic       init_done;

  int n_vec  = 0;
  int n_miss = 0;

  ram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_en    (ram_en),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // RAM model: registered read port; output inverted when not freshly read.
  logic [3:0] mem [16];
  logic [3:0] rd_q = 4'h0;
  logic       rd_vld_q = 1'b0;
  always @(posedge clk) begin
    if (ram_en && ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_wr) rd_q <= mem[ram_addr];
    rd_vld_q <= ram_en && !ram_wr;
  end
  assign ram_rdata = rd_vld_q ? rd_q : ~rd_q;

`ifdef RAM_CTRL_CLEAR_EN
  localparam logic RST_INIT_DONE = 1'b0;
  localparam bit   CLEARED       = 1'b1;
`else
  localparam logic RST_INIT_DONE = 1'b1;
  localparam bit   CLEARED       = 1'b0;
`endif

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [3:0] data;   // write data, or expected read data
    int         stall;  // cycles rsp_ready is held low after rsp_valid rises
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 40) begin
      tick();
      n++;
    end
    check1("req_ready_wait", req_ready, 1'b1);
  endtask

  // Checks the cycles after rst falls (INIT sweep, or immediate readiness).
  task automatic after_reset();
`ifdef RAM_CTRL_CLEAR_EN
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 4'h6;
    req_wdata = 4'h5;
    for (int i = 0; i < 16; i++) begin
      tick();
      check1("init_en", ram_en, 1'b1);
      check1("init_wr", ram_wr, 1'b1);
      check4("init_addr", ram_addr, 4'(i));
      check4("init_wdata", ram_wdata, 4'h0);
      check1("init_done_low", init_done, 1'b0);
      check1("init_ready_low", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    tick();
    check1("init_end_en", ram_en, 1'b0);
    check1("init_done_high", init_done, 1'b1);
    check1("init_end_ready", req_ready, 1'b1);
`else
    check1("init_done_const", init_done, 1'b1);
    check1("ready_after_rst", req_ready, 1'b1);
`endif
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [3:0] data);
    wait_ready();
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
    check1("wr_en", ram_en, 1'b1);
    check1("wr_wr", ram_wr, 1'b1);
    check4("wr_addr", ram_addr, addr);
    check4("wr_wdata", ram_wdata, data);
    check1("wr_busy", req_ready, 1'b0);
    tick();
    check1("wr_en_drop", ram_en, 1'b0);
    check1("wr_ready_back", req_ready, 1'b1);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [3:0] exp, input int stall);
    wait_ready();
    rsp_ready = (stall == 0);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    check1("rd_en", ram_en, 1'b1);
    check1("rd_wr", ram_wr, 1'b0);
    check4("rd_addr", ram_addr, addr);
    check1("rd_vld_early1", rsp_valid, 1'b0);
    tick();
    check1("rd_en_drop", ram_en, 1'b0);
    check1("rd_vld_early2", rsp_valid, 1'b0);
    tick();
    check1("rd_vld", rsp_valid, 1'b1);
    check4("rd_data", rsp_data, exp);
    check1("rd_busy", req_ready, 1'b0);
    for (int k = 0; k < stall; k++) begin
      tick();
      check1("stall_vld", rsp_valid, 1'b1);
      check4("stall_data", rsp_data, exp);
      check1("stall_en", ram_en, 1'b0);
      check1("stall_busy", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    check1("rsp_release", rsp_valid, 1'b0);
    check1("rsp_ready_back", req_ready, 1'b1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{wr: 1'b1, addr: 4'h3, data: 4'hA, stall: 0};
    vecs[1]  = '{wr: 1'b0, addr: 4'h3, data: 4'hA, stall: 0};
    vecs[2]  = '{wr: 1'b0, addr: 4'h3, data: 4'hA, stall: 5};
    vecs[3]  = '{wr: 1'b1, addr: 4'hF, data: 4'h1, stall: 0};
    vecs[4]  = '{wr: 1'b1, addr: 4'h0, data: 4'hF, stall: 0};
    vecs[5]  = '{wr: 1'b0, addr: 4'hF, data: 4'h1, stall: 0};
    vecs[6]  = '{wr: 1'b0, addr: 4'h0, data: 4'hF, stall: 0};
    vecs[7]  = '{wr: 1'b1, addr: 4'h3, data: 4'h0, stall: 0};
    vecs[8]  = '{wr: 1'b0, addr: 4'h3, data: 4'h0, stall: 2};
    vecs[9]  = '{wr: 1'b1, addr: 4'h8, data: 4'h6, stall: 0};
    vecs[10] = '{wr: 1'b0, addr: 4'h8, data: 4'h6, stall: 1};

    // Reset with a write request pending: nothing may be issued.
    rst       = 1'b1;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 4'h3;
    req_wdata = 4'h9;
    rsp_ready = 1'b0;
    tick();
    tick();
    check1("rst_ram_en", ram_en, 1'b0);
    check1("rst_ram_wr", ram_wr, 1'b0);
    check4("rst_ram_addr", ram_addr, 4'h0);
    check4("rst_ram_wdata", ram_wdata, 4'h0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check4("rst_rsp_data", rsp_data, 4'h0);
    check1("rst_init_done", init_done, RST_INIT_DONE);
    check1("rst_req_ready", req_ready, RST_INIT_DONE);
    req_valid = 1'b0;
    rst       = 1'b0;
    after_reset();
    if (CLEARED) do_read(4'h9, 4'h0, 0);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data);
      else            do_read(vecs[v].addr, vecs[v].data, vecs[v].stall);
    end

    // Write sweep with req_valid held high: accepted every other cycle.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_addr  = 4'(i);
      req_wdata = 4'(i);
      check1("b2b_ready", req_ready, 1'b1);
      tick();
      check1("b2b_en", ram_en, 1'b1);
      check4("b2b_addr", ram_addr, 4'(i));
      check4("b2b_wdata", ram_wdata, 4'(i));
      check1("b2b_busy", req_ready, 1'b0);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) do_read(4'(i), 4'(i), 0);
    do_read(4'h0, 4'h0, 0);

    // Reset while in RDCAP of a read to addr 7: response discarded.
    wait_ready();
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 4'h7;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check1("abort_en", ram_en, 1'b0);
    check1("abort_wr", ram_wr, 1'b0);
    check4("abort_addr", ram_addr, 4'h0);
    check4("abort_wdata", ram_wdata, 4'h0);
    check1("abort_rsp_valid", rsp_valid, 1'b0);
    check4("abort_rsp_data", rsp_data, 4'h0);
    rst = 1'b0;
    after_reset();
    check1("abort_no_rsp", rsp_valid, 1'b0);
    do_read(4'h7, CLEARED ? 4'h0 : 4'h7, 0);
    do_read(4'h3, CLEARED ? 4'h0 : 4'h3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
    $fatal(1);
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Single-port initiator for the 16x4 RAM. Accepts read/write requests on a valid/ready request port, drives the RAM's enable/write/address/data strobes with correct one-cycle RAM read latency, and returns read data on a valid/ready response port. Sits between any requesting block (CPU/DMA/test sequencer) and the RAM.

## Interface
Parameters: none (geometry fixed at 16 words x 4 bits).
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  4  word address
- req_wdata  in  4  write data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer takes rsp_data
- rsp_data  out  4  read data
- ram_en  out  1  RAM enable strobe
- ram_wr  out  1  RAM write select
- ram_addr  out  4  RAM address
- ram_wdata  out  4  RAM write data
- ram_rdata  in  4  RAM registered output
- init_done  out  1  controller ready for traffic after reset

## Operation
- States: INIT (macro only), IDLE, WRITE, READ, RDCAP, RSP. All ram_*, rsp_*, init_done are registered; req_ready = (state==IDLE) & init_done.
- IDLE: on req_valid & req_ready, latch req_addr/req_wdata; go WRITE if req_wr=1, else READ. No request -> stay IDLE, ram_en=0.
- WRITE: one cycle, ram_en=1, ram_wr=1, ram_addr/ram_wdata = latched values; -> IDLE.
- READ: one cycle, ram_en=1, ram_wr=0, ram_addr = latched; -> RDCAP.
- RDCAP: ram_en=0; ram_rdata sampled at end of this cycle into rsp_data, rsp_valid<=1; -> RSP. ram_rdata is never sampled in any other state (RAM outputs X when en=0).
- RSP: hold rsp_valid=1 and rsp_data stable until rsp_ready=1; on handshake rsp_valid<=0, -> IDLE. rsp_ready ignored while rsp_valid=0.
- ram_en=0 and ram_wr=0 in every state except WRITE/READ/INIT strobes.
- Reset: all outputs 0 (ram_en, ram_wr, ram_addr, ram_wdata, rsp_valid, rsp_data); init_done per Configuration. Reset mid-operation aborts: pending write not issued if still in IDLE latch, pending read response discarded, ram_en=0 in the cycle after the reset edge.

## Timing
- Request accepted at edge E0. Write: strobe during cycle E0..E1, RAM stores at E1; req_ready high again after E1 (2 cycles/write).
- Read: strobe during E0..E1, RAM data valid E1..E2, captured at E2, rsp_valid high from E2. Minimum request-to-response latency 2 edges; next request accepted no earlier than the edge after the response handshake.
- Back-to-back: one outstanding transaction maximum; req_ready=0 in WRITE, READ, RDCAP, RSP, INIT.

## Configuration
- RAM_CTRL_CLEAR_EN defined: reset enters INIT, init_done resets to 0. Starting at the first edge with rst=0, issues 16 consecutive write strobes (ram_en=1, ram_wr=1, ram_wdata=0, ram_addr=0..15, one per cycle). After the address-15 strobe: ram_en<=0, init_done<=1, -> IDLE. rst asserted during INIT restarts the sweep from address 0.
- Not defined: no INIT state, reset enters IDLE, init_done resets to 1 and stays 1; RAM contents after reset unspecified.

## Test plan
- Write 0xA to addr 3, read addr 3 -> ram_en/ram_wr high one cycle with ram_addr=3, ram_wdata=0xA; response rsp_data=0xA exactly 2 edges after read accept.
- Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable for 5 cycles, req_ready=0, no ram_en pulse; releases one cycle after rsp_ready=1.
- Write 0x0..0xF to addr 0..15 with req_valid held high, read all back -> data matches, req_ready low every other cycle, addr 15 -> 0 sequence clean.
- rst asserted in RDCAP of a read to addr 7 -> no rsp_valid ever for it, all outputs 0 next cycle, next request served normally.
- With RAM_CTRL_CLEAR_EN: release reset -> 16 strobes addr 0..15 data 0, init_done=1 in 17th cycle; read addr 9 returns 0x0; req_valid during INIT ignored.
- Without macro: init_done=1 from reset, first request accepted in first cycle after rst deasserts.
